// File: rtl/ufm_pkg.sv
// Shared definitions for the UFM configuration loader: FSM encoding, word type,
// checksum seed and the word offsets of the sg/ps configuration map.
package ufm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_CHECK     = 3'd3,
    ST_RETRY     = 3'd4
  } ufm_state_t;

  localparam int UFM_DATA_W = 32;
  typedef logic [UFM_DATA_W-1:0] ufm_word_t;

  localparam ufm_word_t CHK_SEED = '0;

  // Word offsets inside cfg_image; the consumer slices fields from these words.
  localparam int CFG_PSREF_WORD  = 0;
  localparam int CFG_SGDPN_WORD  = 1;
  localparam int CFG_RELAY_WORD  = 2;
  localparam int CFG_RELAY_BITS  = 8;
  localparam int CFG_TIMING_WORD = 3;

  function automatic int unsigned burst_len(input int unsigned remain,
                                            input int unsigned burst_max);
    return (remain < burst_max) ? remain : burst_max;
  endfunction

endpackage

// File: rtl/ufm_burst_rd.sv
// Avalon-MM burst read engine: request handshake, burst sizing, beat counting
// and inter-beat timeout. Phases are driven by the loader FSM.
module ufm_burst_rd
  import ufm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 1023,
  parameter int TOTAL     = 7,
  parameter int IDX_W     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req_phase,
  input  logic              wait_phase,
  output logic              avm_read,
  output logic [ADDR_W-1:0] avm_address,
  output logic [3:0]        avm_burstcount,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              accepted,
  output logic              beat_valid,
  output logic [IDX_W-1:0]  beat_idx,
  output logic [DATA_W-1:0] beat_data,
  output logic              burst_done,
  output logic              timeout
);

  localparam int TM_W = $clog2(TIMEOUT + 1);

  logic [IDX_W-1:0] idx_reg;
  logic [3:0]       left_reg;
  logic [TM_W-1:0]  timer_reg;

  // idx_reg is frozen during REQ, so address and burstcount hold through stalls.
  assign avm_read       = req_phase;
  assign avm_address    = ADDR_W'(BASE_ADDR) + ADDR_W'(idx_reg);
  assign avm_burstcount = 4'(burst_len(32'(TOTAL) - 32'(idx_reg), 32'(BURST_MAX)));

  assign accepted   = req_phase && !avm_waitrequest;
  // Beats outside WAIT_DATA belong to an abandoned burst and are dropped.
  assign beat_valid = wait_phase && avm_readdatavalid && (left_reg != 4'd0);
  assign beat_idx   = idx_reg;
  assign beat_data  = avm_readdata;
  assign burst_done = beat_valid && (left_reg == 4'd1);
  assign timeout    = wait_phase && !beat_valid && (timer_reg == TM_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg   <= '0;
      left_reg  <= '0;
      timer_reg <= '0;
    end else if (clear) begin
      idx_reg   <= '0;
      left_reg  <= '0;
      timer_reg <= '0;
    end else if (accepted) begin
      left_reg  <= avm_burstcount;
      timer_reg <= '0;
    end else if (beat_valid) begin
      idx_reg   <= idx_reg + IDX_W'(1);
      left_reg  <= left_reg - 4'd1;
      timer_reg <= '0;
    end else if (wait_phase && !timeout) begin
      timer_reg <= timer_reg + TM_W'(1);
    end
  end

endmodule

// File: rtl/ufm_cfg_loader.sv
// Boot-time loader: reads a checksummed configuration image from UFM, retries on
// failure and commits the image atomically to cfg_image.
module ufm_cfg_loader
  import ufm_pkg::*;
#(
  parameter int NUM_WORDS = 6,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 16,
  parameter int BASE_ADDR = 0,
  parameter int BURST_MAX = 4,
  parameter int TIMEOUT   = 1023,
  parameter int RETRIES   = 2,
  parameter int CHECK_EN  = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  output logic                        avm_read,
  output logic [ADDR_W-1:0]           avm_address,
  output logic [3:0]                  avm_burstcount,
  input  logic                        avm_waitrequest,
  input  logic                        avm_readdatavalid,
  input  logic [DATA_W-1:0]           avm_readdata,
  output logic [NUM_WORDS*DATA_W-1:0] cfg_image,
  output logic                        cfg_valid,
  output logic                        cfg_error,
  output logic                        busy
);

  localparam int TOTAL = NUM_WORDS + CHECK_EN;
  localparam int IDX_W = $clog2(TOTAL + 1);
  localparam int ATT_W = $clog2(RETRIES + 2);

  ufm_state_t state_reg, state_next;

  logic              accepted, beat_valid, burst_done, timeout;
  logic [IDX_W-1:0]  beat_idx;
  logic [DATA_W-1:0] beat_data;
  logic              req_phase, wait_phase;
  logic              load_go, retry_go, clear_buf, commit, give_up;

  logic [ATT_W-1:0]  attempt_reg;
  logic [DATA_W-1:0] sum_reg, chk_reg, total_sum;
  logic              cfg_valid_reg, cfg_error_reg, busy_reg;

  logic last_beat, sum_ok, retry_ok;

  assign total_sum = sum_reg + chk_reg;
  assign sum_ok    = (CHECK_EN == 0) || (total_sum == '0);
  assign retry_ok  = attempt_reg < ATT_W'(RETRIES);
  assign last_beat = burst_done && (beat_idx == IDX_W'(TOTAL - 1));

  ufm_burst_rd #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .BURST_MAX(BURST_MAX),
    .TIMEOUT(TIMEOUT), .TOTAL(TOTAL), .IDX_W(IDX_W)
  ) u_burst_rd (
    .clk(clk), .reset(reset), .clear(clear_buf),
    .req_phase(req_phase), .wait_phase(wait_phase),
    .avm_read(avm_read), .avm_address(avm_address), .avm_burstcount(avm_burstcount),
    .avm_waitrequest(avm_waitrequest), .avm_readdatavalid(avm_readdatavalid),
    .avm_readdata(avm_readdata),
    .accepted(accepted), .beat_valid(beat_valid), .beat_idx(beat_idx),
    .beat_data(beat_data), .burst_done(burst_done), .timeout(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:      if (start) state_next = ST_REQ;
      ST_REQ:       if (accepted) state_next = ST_WAIT_DATA;
      ST_WAIT_DATA: begin
        if (timeout)         state_next = ST_RETRY;
        else if (last_beat)  state_next = ST_CHECK;
        else if (burst_done) state_next = ST_REQ;
      end
      ST_CHECK:     state_next = sum_ok ? ST_IDLE : ST_RETRY;
      ST_RETRY:     state_next = retry_ok ? ST_REQ : ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_phase  = (state_reg == ST_REQ);
    wait_phase = (state_reg == ST_WAIT_DATA);
    load_go    = 1'b0;
    retry_go   = 1'b0;
    commit     = 1'b0;
    give_up    = 1'b0;
    case (state_reg)
      ST_IDLE:  load_go = start;
      ST_CHECK: commit  = sum_ok;
      ST_RETRY: begin
        retry_go = retry_ok;
        give_up  = !retry_ok;
      end
      default: ;
    endcase
    clear_buf = load_go || retry_go;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      attempt_reg   <= '0;
      sum_reg       <= '0;
      chk_reg       <= '0;
      cfg_valid_reg <= 1'b0;
      cfg_error_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      if (clear_buf) begin
        sum_reg <= DATA_W'(CHK_SEED);
        chk_reg <= '0;
      end else if (beat_valid) begin
        if (beat_idx < IDX_W'(NUM_WORDS)) sum_reg <= sum_reg + beat_data;
        else                              chk_reg <= beat_data;
      end
      if (load_go) begin
        attempt_reg   <= '0;
        cfg_valid_reg <= 1'b0;
        cfg_error_reg <= 1'b0;
        busy_reg      <= 1'b1;
      end
      if (retry_go) attempt_reg <= attempt_reg + ATT_W'(1);
      if (commit) begin
        cfg_valid_reg <= 1'b1;
        busy_reg      <= 1'b0;
      end
      if (give_up) begin
        cfg_error_reg <= 1'b1;
        busy_reg      <= 1'b0;
      end
    end
  end

  // Shadow words fill during the attempt; the visible image only moves on commit.
  for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
    logic [DATA_W-1:0] shadow_reg, image_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow_reg <= '0;
        image_reg  <= '0;
      end else begin
        if (clear_buf)
          shadow_reg <= '0;
        else if (beat_valid && beat_idx == IDX_W'(gi))
          shadow_reg <= beat_data;
        if (commit) image_reg <= shadow_reg;
      end
    end

    assign cfg_image[gi*DATA_W +: DATA_W] = image_reg;
  end

  assign cfg_valid = cfg_valid_reg;
  assign cfg_error = cfg_error_reg;
  assign busy      = busy_reg;

endmodule
